// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Shares one FIFO push port among NREQ requesters using round-robin
// arbitration. The controller tracks FIFO occupancy itself and can empty the
// FIFO on request with back-to-back pops.
//
// Every output is registered. full/empty are decoded from the registered
// level.
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high
//   req           per-requester push request (bit i = requester i)
//   req_data      requester i word at [i*W +: W]
//   drain         request to empty the FIFO
//   gnt           one-hot grant, high in the cycle the granted word is pushed
//   fifo_push     push strobe to the FIFO
//   fifo_data_in  word accompanying fifo_push (zero when not pushing)
//   fifo_pop      pop strobe to the FIFO
//   level         tracked FIFO occupancy
//   state         00 IDLE, 01 FILL, 10 DRAIN
//   full          level == DEPTH
//   empty         level == 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no push last edge; waiting for a request or a drain
// FILL  | a word was granted and pushed on the last edge
// DRAIN | popping one word per edge until level reaches 0; no grants
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*W-1:0]          req_data,
  input  logic                       drain,
  output logic [NREQ-1:0]            gnt,
  output logic                       fifo_push,
  output logic [W-1:0]               fifo_data_in,
  output logic                       fifo_pop,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [1:0]                 state,
  output logic                       full,
  output logic                       empty
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  state_t           st_q;
  state_t           st_d;
  // rr_ptr_q holds the index that gets first look on the next arbitration,
  // i.e. (last granted + 1) mod NREQ.
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [LVL_W-1:0] level_d;
  logic [NREQ-1:0]  gnt_d;
  logic             push_d;
  logic             pop_d;
  logic [W-1:0]     data_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: walk NREQ positions starting at rr_ptr_q, wrapping at
  // NREQ-1, and take the first active request.
  // ---------------------------------------------------------------------------
  logic             arb_found;
  logic [PTR_W-1:0] arb_sel;
  logic [PTR_W-1:0] arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
      arb_idx = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_ONE;
    end
  end

  // Winner's one-hot grant and data word.
  logic [NREQ-1:0] sel_onehot;
  logic [W-1:0]    sel_data;

  always_comb begin
    sel_onehot = '0;
    sel_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel == PTR_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_data      = req_data[i*W +: W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output values
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d     = st_q;
    rr_ptr_d = rr_ptr_q;
    level_d  = level;
    gnt_d    = '0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    data_d   = '0;

    case (st_q)
      ST_DRAIN: begin
        // Drain runs to completion regardless of the drain input. The pop
        // that takes level to zero also returns the controller to IDLE.
        if (level != '0) begin
          pop_d   = 1'b1;
          level_d = level - LVL_ONE;
          if (level == LVL_ONE) begin
            st_d = ST_IDLE;
          end
        end else begin
          st_d = ST_IDLE;
        end
      end

      default: begin
        // IDLE and FILL share arbitration; drain wins over any request on the
        // same edge, but only when there is something to drain.
        if (drain && (level != '0)) begin
          st_d = ST_DRAIN;
        end else if (arb_found && (level < LVL_MAX)) begin
          st_d     = ST_FILL;
          gnt_d    = sel_onehot;
          push_d   = 1'b1;
          data_d   = sel_data;
          level_d  = level + LVL_ONE;
          rr_ptr_d = (arb_sel == PTR_LAST) ? '0 : arb_sel + PTR_ONE;
        end else begin
          st_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      rr_ptr_q     <= '0;
      level        <= '0;
      gnt          <= '0;
      fifo_push    <= 1'b0;
      fifo_pop     <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      st_q         <= st_d;
      rr_ptr_q     <= rr_ptr_d;
      level        <= level_d;
      gnt          <= gnt_d;
      fifo_push    <= push_d;
      fifo_pop     <= pop_d;
      fifo_data_in <= data_d;
    end
  end

  assign state = st_q;
  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

endmodule
